// File: rtl/latent_proj_fc.sv
// Fully-connected projection: buffers one latent vector, then for each row computes
// bias + W[row].z serially and emits the saturated, shifted result as a framed stream.
module latent_proj_fc #(
  parameter int DATA_WIDTH = 16,
  parameter int LATENT_DIM = 8,
  parameter int OUT_LEN    = 16,
  parameter int SHIFT      = 2
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic signed [DATA_WIDTH-1:0]          in_data,
  input  logic                                  wr_en,
  input  logic                                  wr_sel,
  input  logic [$clog2(OUT_LEN*LATENT_DIM)-1:0] wr_addr,
  input  logic signed [DATA_WIDTH-1:0]          wr_data,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic signed [DATA_WIDTH-1:0]          out_data,
  output logic                                  out_first,
  output logic                                  out_last
);

  localparam int DW   = DATA_WIDTH;
  localparam int AW   = $clog2(OUT_LEN*LATENT_DIM);
  localparam int EW   = $clog2(LATENT_DIM);
  localparam int CW   = $clog2(LATENT_DIM+1);
  localparam int RW   = (OUT_LEN > 1) ? $clog2(OUT_LEN) : 1;
  localparam int ACCW = 2*DW + $clog2(LATENT_DIM) + 1;

  localparam logic signed [ACCW-1:0] SAT_MAX = {{(ACCW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACCW-1:0] SAT_MIN = {{(ACCW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {LOAD, MAC, EMIT} state_t;

  state_t                 state_q, state_d;
  logic [EW-1:0]          elem_q, elem_d;
  logic [RW-1:0]          row_q, row_d;
  logic [CW-1:0]          col_q, col_d;
  logic signed [ACCW-1:0] acc_q, acc_d;

  logic signed [DW-1:0] w_mem [OUT_LEN*LATENT_DIM];
  logic signed [DW-1:0] b_mem [OUT_LEN];
  logic signed [DW-1:0] z_mem [LATENT_DIM];

  logic [AW-1:0]          w_idx;
  logic signed [DW-1:0]   w_rd, z_rd, b_rd;
  logic signed [2*DW-1:0] prod;
  logic signed [ACCW-1:0] shifted;
  logic [31:0]            wr_addr_ext;
  logic                   wr_ok;
  logic                   accept;

  assign accept      = (state_q == LOAD) && in_valid && !rst;
  assign wr_ok       = wr_en && !rst && (state_q == LOAD) && (elem_q == '0);
  assign wr_addr_ext = 32'(wr_addr);

  // col_q==0 is the bias-load cycle; col_q==k+1 accumulates product k
  assign w_idx = AW'(row_q) * AW'(LATENT_DIM) + AW'(col_q - 1'b1);
  assign w_rd  = w_mem[w_idx];
  assign z_rd  = z_mem[EW'(col_q - 1'b1)];
  assign b_rd  = b_mem[row_q];
  assign prod  = w_rd * z_rd;

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      if (!wr_sel) begin
        if (wr_addr_ext < 32'(OUT_LEN*LATENT_DIM)) w_mem[wr_addr] <= wr_data;
      end else begin
        if (wr_addr_ext < 32'(OUT_LEN)) b_mem[RW'(wr_addr)] <= wr_data;
      end
    end
    if (accept) z_mem[elem_q] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOAD;
      elem_q  <= '0;
      row_q   <= '0;
      col_q   <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      elem_q  <= elem_d;
      row_q   <= row_d;
      col_q   <= col_d;
      acc_q   <= acc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    elem_d  = elem_q;
    row_d   = row_q;
    col_d   = col_q;
    acc_d   = acc_q;
    unique case (state_q)
      LOAD: begin
        if (in_valid) begin
          if (elem_q == EW'(LATENT_DIM-1)) begin
            state_d = MAC;
            elem_d  = '0;
            row_d   = '0;
            col_d   = '0;
          end else begin
            elem_d = elem_q + 1'b1;
          end
        end
      end
      MAC: begin
        if (col_q == '0) begin
          acc_d = ACCW'(b_rd);
          col_d = col_q + 1'b1;
        end else begin
          acc_d = acc_q + ACCW'(prod);
          if (col_q == CW'(LATENT_DIM)) begin
            state_d = EMIT;
            col_d   = '0;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      EMIT: begin
        if (out_ready) begin
          if (row_q == RW'(OUT_LEN-1)) begin
            state_d = LOAD;
            row_d   = '0;
          end else begin
            state_d = MAC;
            row_d   = row_q + 1'b1;
            col_d   = '0;
          end
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_comb begin
    shifted   = acc_q >>> SHIFT;
    in_ready  = (state_q == LOAD) && !rst;
    out_valid = (state_q == EMIT);
    out_first = (state_q == EMIT) && (row_q == '0);
    out_last  = (state_q == EMIT) && (row_q == RW'(OUT_LEN-1));
    out_data  = '0;
    if (state_q == EMIT) begin
      if (shifted > SAT_MAX)      out_data = SAT_MAX[DW-1:0];
      else if (shifted < SAT_MIN) out_data = SAT_MIN[DW-1:0];
      else                        out_data = shifted[DW-1:0];
    end
  end

endmodule
